// File: rtl/puf_host_requester.sv
// puf_host_requester: host-side initiator of the PUF UART exchange.
// Sends REQUEST_ID and a challenge byte, then collects RESPONSE_ID followed by
// NUM_WORDS big-endian words of four bytes each. Each word is presented with a
// one-cycle resp_valid strobe. Silence between received bytes aborts the request.
// WORD_BITS is expected to be exactly 4*DATA_BITS.
module puf_host_requester #(
  parameter int                   DATA_BITS      = 8,
  parameter int                   WORD_BITS      = 32,
  parameter int                   NUM_WORDS      = 1280,
  parameter logic [DATA_BITS-1:0] REQUEST_ID     = 8'b10101010,
  parameter logic [DATA_BITS-1:0] RESPONSE_ID    = 8'b10101010,
  parameter int                   TIMEOUT_CYCLES = 50000000,
  localparam int                  IDX_W          = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [7:0]           challenge,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [1:0]           err_code,
  output logic [WORD_BITS-1:0] resp_word,
  output logic                 resp_valid,
  output logic [IDX_W-1:0]     resp_index,
  output logic [DATA_BITS-1:0] uart_data_out,
  output logic                 uart_tx_enable,
  input  logic                 uart_tx_busy,
  input  logic [DATA_BITS-1:0] uart_data_in,
  input  logic                 uart_rx_valid,
  output logic                 uart_rx_enable
);

  localparam int                 TMO_W     = $clog2(TIMEOUT_CYCLES + 1);
  // tmo_q counts cycles since the last accepted byte; the abort lands in the
  // cycle where that count would reach TIMEOUT_CYCLES.
  localparam logic [TMO_W-1:0]   TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0]   WORD_LAST = IDX_W'(NUM_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_TX_ID, S_TX_ID_WAIT, S_TX_CHAL, S_TX_CHAL_WAIT, S_RX_ID, S_RX_DATA, S_FINISH
  } state_t;

  state_t                 state_q, state_d;
  logic [7:0]             chal_q, chal_d;
  logic                   seen_busy_q, seen_busy_d;
  logic [1:0]             byte_cnt_q, byte_cnt_d;
  logic [IDX_W-1:0]       word_cnt_q, word_cnt_d;
  logic [TMO_W-1:0]       tmo_q, tmo_d;
  logic [WORD_BITS-1:0]   acc_q, acc_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   error_q, error_d;
  logic [1:0]             err_code_q, err_code_d;
  logic [WORD_BITS-1:0]   resp_word_q, resp_word_d;
  logic                   resp_valid_q, resp_valid_d;
  logic [IDX_W-1:0]       resp_index_q, resp_index_d;
  logic [DATA_BITS-1:0]   data_out_q, data_out_d;
  logic                   tx_en_q, tx_en_d;
  logic                   rx_en_q, rx_en_d;

  logic                   id_check, run_timer, fail;
  logic [1:0]             fail_code;
  logic [WORD_BITS-1:0]   word_next;

  // Next-state and next-output logic for the request/response sequence.
  always_comb begin
    state_d      = state_q;
    chal_d       = chal_q;
    seen_busy_d  = seen_busy_q;
    byte_cnt_d   = byte_cnt_q;
    word_cnt_d   = word_cnt_q;
    tmo_d        = tmo_q;
    acc_d        = acc_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    error_d      = 1'b0;
    err_code_d   = err_code_q;
    resp_word_d  = resp_word_q;
    resp_valid_d = 1'b0;
    resp_index_d = resp_index_q;
    data_out_d   = data_out_q;
    tx_en_d      = 1'b0;
    id_check     = 1'b0;
    run_timer    = 1'b0;
    fail         = 1'b0;
    fail_code    = 2'd0;

    // Accumulator with the incoming byte dropped into its MSB-first slot.
    word_next = acc_q;
    case (byte_cnt_q)
      2'd0:    word_next[4*DATA_BITS-1 -: DATA_BITS] = uart_data_in;
      2'd1:    word_next[3*DATA_BITS-1 -: DATA_BITS] = uart_data_in;
      2'd2:    word_next[2*DATA_BITS-1 -: DATA_BITS] = uart_data_in;
      default: word_next[DATA_BITS-1   -: DATA_BITS] = uart_data_in;
    endcase

    case (state_q)
      S_IDLE: begin
        // A start coinciding with the done/error pulse is dropped.
        if (start && !done_q && !error_q) begin
          chal_d     = challenge;
          err_code_d = 2'd0;
          busy_d     = 1'b1;
          byte_cnt_d = 2'd0;
          word_cnt_d = '0;
          tmo_d      = '0;
          state_d    = S_TX_ID;
        end
      end
      S_TX_ID: begin
        if (!uart_tx_busy) begin
          data_out_d  = REQUEST_ID;
          tx_en_d     = 1'b1;
          seen_busy_d = 1'b0;
          state_d     = S_TX_ID_WAIT;
        end
      end
      S_TX_ID_WAIT: begin
        if (uart_tx_busy)     seen_busy_d = 1'b1;
        else if (seen_busy_q) state_d     = S_TX_CHAL;
      end
      S_TX_CHAL: begin
        if (!uart_tx_busy) begin
          data_out_d  = DATA_BITS'(chal_q);
          tx_en_d     = 1'b1;
          seen_busy_d = 1'b0;
          state_d     = S_TX_CHAL_WAIT;
        end
      end
      S_TX_CHAL_WAIT: begin
        // The device may answer before our transmitter reports idle.
        if (uart_rx_valid) begin
          id_check = 1'b1;
        end else if (uart_tx_busy) begin
          seen_busy_d = 1'b1;
        end else if (seen_busy_q) begin
          tmo_d   = TMO_W'(1);
          state_d = S_RX_ID;
        end
      end
      S_RX_ID: begin
        if (uart_rx_valid) id_check  = 1'b1;
        else               run_timer = 1'b1;
      end
      S_RX_DATA: begin
        if (uart_rx_valid) begin
          acc_d      = word_next;
          tmo_d      = TMO_W'(1);
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            resp_word_d  = word_next;
            resp_valid_d = 1'b1;
            resp_index_d = word_cnt_q;
            if (word_cnt_q == WORD_LAST) state_d    = S_FINISH;
            else                         word_cnt_d = word_cnt_q + 1'b1;
          end
        end else begin
          run_timer = 1'b1;
        end
      end
      S_FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (id_check) begin
      if (uart_data_in == RESPONSE_ID) begin
        byte_cnt_d = 2'd0;
        tmo_d      = TMO_W'(1);
        state_d    = S_RX_DATA;
      end else begin
        fail      = 1'b1;
        fail_code = 2'd1;
      end
    end

    if (run_timer) begin
      if (tmo_q == TMO_LAST) begin
        fail      = 1'b1;
        fail_code = 2'd2;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end

    // Any abort discards the partial word simply by leaving RX_DATA.
    if (fail) begin
      error_d    = 1'b1;
      err_code_d = fail_code;
      busy_d     = 1'b0;
      state_d    = S_IDLE;
    end

    rx_en_d = (state_d != S_IDLE) && (state_d != S_FINISH);
  end

  // State and registered outputs; reset clears everything asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      chal_q       <= '0;
      seen_busy_q  <= 1'b0;
      byte_cnt_q   <= '0;
      word_cnt_q   <= '0;
      tmo_q        <= '0;
      acc_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      err_code_q   <= '0;
      resp_word_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_index_q <= '0;
      data_out_q   <= '0;
      tx_en_q      <= 1'b0;
      rx_en_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      chal_q       <= chal_d;
      seen_busy_q  <= seen_busy_d;
      byte_cnt_q   <= byte_cnt_d;
      word_cnt_q   <= word_cnt_d;
      tmo_q        <= tmo_d;
      acc_q        <= acc_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      err_code_q   <= err_code_d;
      resp_word_q  <= resp_word_d;
      resp_valid_q <= resp_valid_d;
      resp_index_q <= resp_index_d;
      data_out_q   <= data_out_d;
      tx_en_q      <= tx_en_d;
      rx_en_q      <= rx_en_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign error          = error_q;
  assign err_code       = err_code_q;
  assign resp_word      = resp_word_q;
  assign resp_valid     = resp_valid_q;
  assign resp_index     = resp_index_q;
  assign uart_data_out  = data_out_q;
  assign uart_tx_enable = tx_en_q;
  assign uart_rx_enable = rx_en_q;

endmodule

// File: tb/tb_puf_host_requester.sv
// Bench for puf_host_requester: UART TX stand-in, byte-level response model,
// and a per-cycle compare process on the response/done/error outputs.
module tb_puf_host_requester;

  localparam int NW  = 2;
  localparam int TMO = 100;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  challenge = 8'h00;
  logic        busy, done, error;
  logic [1:0]  err_code;
  logic [31:0] resp_word;
  logic        resp_valid;
  logic        resp_index;
  logic [7:0]  uart_data_out;
  logic        uart_tx_enable;
  logic        uart_tx_busy = 1'b0;
  logic [7:0]  uart_data_in = 8'h00;
  logic        uart_rx_valid = 1'b0;
  logic        uart_rx_enable;

  always #5 clk = ~clk;

  puf_host_requester #(
    .DATA_BITS(8), .WORD_BITS(32), .NUM_WORDS(NW),
    .REQUEST_ID(8'hAA), .RESPONSE_ID(8'hAA), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .challenge(challenge),
    .busy(busy), .done(done), .error(error), .err_code(err_code),
    .resp_word(resp_word), .resp_valid(resp_valid), .resp_index(resp_index),
    .uart_data_out(uart_data_out), .uart_tx_enable(uart_tx_enable),
    .uart_tx_busy(uart_tx_busy), .uart_data_in(uart_data_in),
    .uart_rx_valid(uart_rx_valid), .uart_rx_enable(uart_rx_enable)
  );

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ---------------- expected-response model ----------------
  typedef struct { logic [31:0] w; int idx; } exp_t;
  exp_t        exp_q[$];
  logic [31:0] acc = 0;
  int          acc_n = 0;
  int          model_words = 0;
  logic [31:0] seen_words[$];

  function automatic void model_reset();
    exp_q.delete();
    acc = 0; acc_n = 0; model_words = 0;
  endfunction

  // Words are the four data bytes concatenated in arrival order.
  function automatic void model_feed(input logic [7:0] b);
    acc = {acc[23:0], b};
    acc_n++;
    if (acc_n == 4) begin
      if (model_words < NW) exp_q.push_back('{acc, model_words});
      model_words++;
      acc_n = 0;
    end
  endfunction

  // ---------------- UART transmitter stand-in ----------------
  bit          stall = 1'b0;
  int          busy_cnt = 0;
  bit          en_prev = 1'b0;
  logic [7:0]  tx_log[$];

  always @(negedge clk) begin
    if (!reset) begin
      busy_cnt = 0;
      en_prev  = 1'b0;
    end else begin
      if (uart_tx_enable) begin
        check("tx_enable_single_cycle", en_prev, 0);
        check("tx_launch_when_idle", uart_tx_busy, 0);
        tx_log.push_back(uart_data_out);
        $display("tx launch byte=0x%02h", uart_data_out);
        busy_cnt = 4;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
      end
      en_prev = uart_tx_enable;
    end
    uart_tx_busy = (busy_cnt > 0) || stall;
  end

  // ---------------- compare process ----------------
  int cyc = 0;
  int last_rx_cyc = 0;
  int err_cyc = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  bit done_prev = 1'b0;
  bit err_prev = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      if (resp_valid) begin
        if (exp_q.size() == 0) begin
          check("resp_valid_unexpected", resp_valid, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("resp_word", resp_word, e.w);
          check("resp_index", resp_index, e.idx);
          check("resp_latency", cyc - last_rx_cyc, 1);
          seen_words.push_back(resp_word);
          $display("resp idx=%0d word=0x%08h", resp_index, resp_word);
        end
      end
      if (done) begin
        done_cnt++;
        check("done_busy_low", busy, 0);
        check("done_not_error", error, 0);
        check("done_single_cycle", done_prev, 0);
        $display("done err_code=%0d", err_code);
      end
      if (error) begin
        err_cnt++;
        err_cyc = cyc;
        check("error_busy_low", busy, 0);
        check("error_single_cycle", err_prev, 0);
        $display("error err_code=%0d", err_code);
      end
    end
    done_prev = done;
    err_prev  = error;
    if (uart_rx_valid) last_rx_cyc = cyc;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    tick();
    uart_rx_valid = 1'b1;
    uart_data_in  = b;
    tick();
    uart_rx_valid = 1'b0;
  endtask

  task automatic send_data(input logic [7:0] b);
    model_feed(b);
    send_byte(b);
  endtask

  task automatic pulse_start(input logic [7:0] ch);
    tick();
    start = 1'b1;
    challenge = ch;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_tx(input int n);
    for (int i = 0; i < 400 && tx_log.size() < n; i++) tick();
    check("tx_count", tx_log.size(), n);
  endtask

  task automatic wait_done(input int n0);
    for (int i = 0; i < 400 && done_cnt == n0; i++) tick();
    check("done_seen", done_cnt, n0 + 1);
  endtask

  task automatic wait_error(input int n0);
    for (int i = 0; i < 400 && err_cnt == n0; i++) tick();
    check("error_seen", err_cnt, n0 + 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_error"}, error, 0);
    check({tag, "_err_code"}, err_code, 0);
    check({tag, "_resp_word"}, resp_word, 0);
    check({tag, "_resp_valid"}, resp_valid, 0);
    check({tag, "_resp_index"}, resp_index, 0);
    check({tag, "_data_out"}, uart_data_out, 0);
    check({tag, "_tx_enable"}, uart_tx_enable, 0);
    check({tag, "_rx_enable"}, uart_rx_enable, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset state
    repeat (3) tick();
    check_all_zero("reset");
    reset = 1'b1;
    tick();

    // Nominal with a 50-cycle TX stall, early response ID and a start while busy
    model_reset();
    stall = 1'b1;
    pulse_start(8'h5C);
    check("start_busy", busy, 1);
    check("start_rx_enable", uart_rx_enable, 1);
    repeat (50) begin
      @(negedge clk);
      check("stall_no_launch", uart_tx_enable, 0);
    end
    tick();
    stall = 1'b0;
    wait_tx(1);
    check("tx0_request_id", tx_log[0], 8'hAA);
    wait_tx(2);
    check("tx1_challenge", tx_log[1], 8'h5C);
    send_byte(8'hAA);
    send_data(8'h01); send_data(8'h02); send_data(8'h03); send_data(8'h04);
    pulse_start(8'h77);
    send_data(8'hDE); send_data(8'hAD); send_data(8'hBE); send_data(8'hEF);
    wait_done(0);
    tick();
    check("nominal_busy", busy, 0);
    check("nominal_err_code", err_code, 0);
    check("nominal_rx_enable", uart_rx_enable, 0);
    check("nominal_no_relaunch", tx_log.size(), 2);
    check("nominal_chal_kept", tx_log[1], 8'h5C);
    check("nominal_word0", seen_words[0], 32'h01020304);
    check("nominal_word1", seen_words[1], 32'hDEADBEEF);
    check("nominal_all_words", exp_q.size(), 0);

    // Bad response ID
    model_reset();
    n = err_cnt;
    pulse_start(8'h33);
    wait_tx(4);
    check("badid_chal", tx_log[3], 8'h33);
    repeat (8) tick();
    send_byte(8'h55);
    wait_error(n);
    check("badid_latency", err_cyc - last_rx_cyc, 1);
    check("badid_err_code", err_code, 1);
    check("badid_busy", busy, 0);
    check("badid_rx_enable", uart_rx_enable, 0);

    // RX timeout after a partial word
    model_reset();
    n = err_cnt;
    pulse_start(8'h44);
    check("timeout_err_code_cleared", err_code, 0);
    wait_tx(6);
    send_byte(8'hAA);
    send_data(8'h11);
    send_data(8'h22);
    model_reset();
    wait_error(n);
    check("timeout_distance", err_cyc - last_rx_cyc, TMO);
    check("timeout_err_code", err_code, 2);
    check("timeout_busy", busy, 0);

    // Reset in the middle of RX_DATA, then a fresh nominal run
    model_reset();
    pulse_start(8'h5C);
    wait_tx(8);
    send_byte(8'hAA);
    send_data(8'h01);
    send_data(8'h02);
    reset = 1'b0;
    #1;
    check_all_zero("midreset");
    model_reset();
    repeat (3) tick();
    reset = 1'b1;
    repeat (20) tick();
    check("midreset_no_launch", tx_log.size(), 8);
    n = done_cnt;
    pulse_start(8'h5C);
    wait_tx(10);
    check("rerun_tx_id", tx_log[8], 8'hAA);
    check("rerun_tx_chal", tx_log[9], 8'h5C);
    repeat (8) tick();
    send_byte(8'hAA);
    send_data(8'h01); send_data(8'h02); send_data(8'h03); send_data(8'h04);
    send_data(8'hDE); send_data(8'hAD); send_data(8'hBE); send_data(8'hEF);
    wait_done(n);
    tick();
    check("rerun_err_code", err_code, 0);
    check("rerun_word0", seen_words[2], 32'h01020304);
    check("rerun_word1", seen_words[3], 32'hDEADBEEF);
    check("rerun_all_words", exp_q.size(), 0);

    repeat (5) tick();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
